// File: rtl/mem_arbiter.sv
// Single RAM port arbiter between instruction fetch and data load/store, data first by default.
// Define MEM_ARB_FAIR_EN to compile in the fetch starvation guard (bounded by STARVE_LIMIT).
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    typedef enum logic [1:0] {IDLE, DGNT, IGNT} state_t;

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    state_t state_reg, state_next;
    logic   dreq, ram_access, ram_error, force_i;

    assign dreq       = dREN | dWEN;
    assign ram_access = (ramstate == RS_ACCESS);
    assign ram_error  = (ramstate == RS_ERROR);

    // Empty marker block: elaborates only for an out-of-range limit, so it shows up in the hierarchy.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_starve_limit_out_of_range
    end

`ifdef MEM_ARB_FAIR_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_reg, starve_next;

    assign force_i = iREN && (starve_reg == LIMIT);

    always_comb begin
        starve_next = starve_reg;
        if (state_reg == IDLE && state_next == DGNT && iREN) begin
            if (starve_reg != 4'hF)
                starve_next = starve_reg + 4'd1;
        end else if (state_reg == IDLE && state_next == IGNT) begin
            starve_next = 4'd0;
        end else if (state_reg != IDLE && state_next == IDLE && !iREN) begin
            starve_next = 4'd0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            starve_reg <= 4'd0;
        else
            starve_reg <= starve_next;
    end
`else
    assign force_i = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // A grant ends on completion, on error (retry via re-arbitration) or when the request is withdrawn.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (dreq && !force_i)
                    state_next = DGNT;
                else if (iREN)
                    state_next = IGNT;
            end
            DGNT: if (!dreq || ram_access || ram_error) state_next = IDLE;
            IGNT: if (!iREN || ram_access || ram_error) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iwait    = ~(state_reg == IGNT && ram_access);
        dwait    = ~(state_reg == DGNT && ram_access);
        case (state_reg)
            DGNT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN & ~ram_error;
                ramREN   = dREN & ~dWEN & ~ram_error;
            end
            IGNT: begin
                ramaddr = iaddr;
                ramREN  = iREN & ~ram_error;
            end
            default: ;
        endcase
    end

    assign iload = ramload;
    assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a transaction-level ownership model.
module tb_mem_arbiter;
    localparam int LIMIT = 2;
`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        CLK = 1'b0, RST = 1'b1;
    logic        iREN = 0, dREN = 0, dWEN = 0;
    logic [31:0] iaddr = 0, daddr = 0, dstore = 0, ramload = 0;
    logic [1:0]  ramstate = 0;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        iwait, dwait, ramREN, ramWEN;

    int n_checks = 0, n_fail = 0;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Who holds the port: 0 nobody (arbitration cycle), 1 data, 2 fetch.
    int m_owner = 0;
    int m_streak = 0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_owner  <= 0;
            m_streak <= 0;
        end else if (m_owner == 0) begin
            if ((dREN || dWEN) && !(FAIR && iREN && m_streak == LIMIT)) begin
                m_owner <= 1;
                if (iREN) m_streak <= (m_streak < 15) ? m_streak + 1 : 15;
            end else if (iREN) begin
                m_owner  <= 2;
                m_streak <= 0;
            end
        end else begin
            if (((m_owner == 1) ? !(dREN || dWEN) : !iREN) || ramstate == 2'd2 || ramstate == 2'd3) begin
                m_owner <= 0;
                if (!iREN) m_streak <= 0;
            end
        end
    end

    logic [31:0] e_addr, e_store;
    logic        e_ren, e_wen, e_ok;
    logic        dwait_s = 1'b1, iwait_s = 1'b1;

    always @(negedge CLK) begin
        e_ok = (ramstate != 2'd3);
        e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
        if (m_owner == 1) begin
            e_addr  = daddr;
            e_store = dstore;
            e_wen   = dWEN && e_ok;
            e_ren   = dREN && !dWEN && e_ok;
        end else if (m_owner == 2) begin
            e_addr = iaddr;
            e_ren  = iREN && e_ok;
        end
        check("ramREN", ramREN, e_ren);
        check("ramWEN", ramWEN, e_wen);
        check("ramaddr", ramaddr, e_addr);
        check("ramstore", ramstore, e_store);
        check("iwait", iwait, !(m_owner == 2 && ramstate == 2'd2));
        check("dwait", dwait, !(m_owner == 1 && ramstate == 2'd2));
        check("iload", iload, ramload);
        check("dload", dload, ramload);
        dwait_s = dwait;
        iwait_s = iwait;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic samp();
        @(negedge CLK);
    endtask

    logic [5:0] grant_code;
    int         n_grants;
    bit         d_on, i_on;

    initial begin
        // Reset state
        samp();
        check("rst_ramREN", ramREN, 0);
        check("rst_ramaddr", ramaddr, 0);
        check("rst_iwait", iwait, 1);
        check("rst_dwait", dwait, 1);
        step(); RST = 0;

        // Async reset in the middle of a fetch grant
        iREN = 1; iaddr = 32'h80; ramstate = 2'd1;
        samp();
        step();
        samp(); check("pre_rst_ramREN", ramREN, 1);
        #2 RST = 1;
        #1;
        check("async_rst_ramREN", ramREN, 0);
        check("async_rst_iwait", iwait, 1);
        check("async_rst_dwait", dwait, 1);
        step(); RST = 0; iREN = 0; ramstate = 2'd0;
        samp(); check("post_rst_ramREN", ramREN, 0);

        // Single fetch, ACCESS on the first grant cycle
        step(); iREN = 1; iaddr = 32'h40; ramstate = 2'd1;
        samp(); check("f0_iwait", iwait, 1); check("f0_ramREN", ramREN, 0);
        step(); ramstate = 2'd2; ramload = 32'h8C220004;
        samp();
        check("f1_ramREN", ramREN, 1);
        check("f1_ramaddr", ramaddr, 32'h40);
        check("f1_iwait", iwait, 0);
        check("f1_iload", iload, 32'h8C220004);
        step(); iREN = 0; ramstate = 2'd0;
        samp(); check("f2_ramREN", ramREN, 0);

        // Contention: data store wins, fetch follows after the idle cycle
        step(); iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramstate = 2'd1;
        samp();
        step();
        samp();
        check("c1_ramWEN", ramWEN, 1); check("c1_ramREN", ramREN, 0);
        check("c1_ramaddr", ramaddr, 32'h100); check("c1_ramstore", ramstore, 32'hDEADBEEF);
        check("c1_dwait", dwait, 1);
        step();
        samp(); check("c2_dwait", dwait, 1);
        step(); ramstate = 2'd2;
        samp(); check("c3_dwait", dwait, 0); check("c3_iwait", iwait, 1);
        step(); dWEN = 0; ramstate = 2'd1;
        samp(); check("c4_ramREN", ramREN, 0);
        step(); ramstate = 2'd2;
        samp();
        check("c5_ramREN", ramREN, 1); check("c5_ramaddr", ramaddr, 32'h44); check("c5_iwait", iwait, 0);
        step(); iREN = 0; ramstate = 2'd0;
        samp();

        // Error then retry
        step(); dREN = 1; daddr = 32'h200;
        samp();
        step(); ramstate = 2'd3;
        samp(); check("e1_dwait", dwait, 1); check("e1_ramREN", ramREN, 0);
        step(); ramstate = 2'd0;
        samp(); check("e2_ramREN", ramREN, 0); check("e2_dwait", dwait, 1);
        step(); ramstate = 2'd2;
        samp(); check("e3_ramREN", ramREN, 1); check("e3_dwait", dwait, 0);
        step(); dREN = 0; ramstate = 2'd0;
        samp();

        // Abort during a BUSY data grant
        step(); dREN = 1; daddr = 32'h300; ramstate = 2'd1;
        samp();
        step();
        samp(); check("a1_ramREN", ramREN, 1);
        step(); dREN = 0;
        samp(); check("a2_ramREN", ramREN, 0); check("a2_dwait", dwait, 1);
        step(); dREN = 1;
        samp(); check("a3_idle_ramREN", ramREN, 0);
        step();
        samp(); check("a4_ramREN", ramREN, 1);
        step(); dREN = 0; ramstate = 2'd0;
        samp();

        // Continuous data traffic with a pending fetch
        step(); dREN = 1; daddr = 32'h20; iREN = 1; iaddr = 32'h10; ramstate = 2'd2;
        grant_code = 0; n_grants = 0;
        for (int c = 0; c < 12; c++) begin
            samp();
            if (!dwait || !iwait) begin
                if (n_grants < 6) grant_code[5 - n_grants] = !iwait;
                n_grants++;
            end
            step();
        end
        check("grant_count", n_grants, 6);
        check("grant_order", {26'd0, grant_code}, FAIR ? 32'b001001 : 32'b000000);
        dREN = 0; iREN = 0; ramstate = 2'd0;
        samp();

        // Randomized traffic; requesters hold until done except for occasional aborts
        d_on = 0; i_on = 0;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (d_on && (!dwait_s || $urandom_range(19) == 0)) d_on = 0;
            if (!d_on && $urandom_range(2) == 0) begin
                int op;
                op = $urandom_range(2);
                d_on = 1;
                dREN = (op != 1);
                dWEN = (op != 0);
                daddr = $urandom;
                dstore = $urandom;
            end
            if (!d_on) begin dREN = 0; dWEN = 0; end
            if (i_on && (!iwait_s || $urandom_range(29) == 0)) i_on = 0;
            if (!i_on && $urandom_range(1) == 0) begin
                i_on = 1;
                iaddr = $urandom;
            end
            iREN = i_on;
            begin
                int r;
                r = $urandom_range(9);
                ramstate = (r < 4) ? 2'd2 : (r < 7) ? 2'd1 : (r < 9) ? 2'd0 : 2'd3;
            end
            ramload = $urandom;
            samp();
        end
        step(); dREN = 0; dWEN = 0; iREN = 0; ramstate = 2'd0;
        samp();
        step();
        samp();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the instruction-fetch path (`imem*`) and the data path (`dmem*`, driven by memory/writeback-side load and store traffic) of the pipelined CPU. It owns the one RAM port, grants it to one requester per transaction, and returns wait/load signals. By default data requests have priority. A starvation guard can be compiled in so fetch is not locked out by back-to-back data accesses.

## Interface
- `STARVE_LIMIT`, default 4: consecutive data grants allowed while a fetch is pending before the fetch is forced through. Legal range is 1–15. Only used when `MEM_ARB_FAIR_EN` is defined.
- `CLK` in 1: clock. All state updates on the rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `iREN` in 1: instruction read request.
- `iaddr` in 32: instruction word address.
- `iload` out 32: instruction read data.
- `iwait` out 1: instruction request not complete.
- `dREN` in 1: data read request.
- `dWEN` in 1: data write request.
- `daddr` in 32: data address.
- `dstore` in 32: data write value.
- `dload` out 32: data read data.
- `dwait` out 1: data request not complete.
- `ramREN` out 1: RAM read enable.
- `ramWEN` out 1: RAM write enable.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data.
- `ramstate` in 2: RAM status. 0=FREE, 1=BUSY, 2=ACCESS, 3=ERROR.

## Operation
- FSM states: IDLE, DGNT, IGNT. Reset enters IDLE.
- IDLE
  - If `dREN|dWEN`, go to DGNT.
  - Else if `iREN`, go to IGNT.
  - Else stay in IDLE.
  - RAM enables are 0 in IDLE.
- DGNT
  - `ramaddr=daddr`, `ramstore=dstore`.
  - `ramWEN=dWEN`, `ramREN=dREN&~dWEN`. If `dREN` and `dWEN` are both high, the transaction is a write.
- IGNT
  - `ramaddr=iaddr`, `ramREN=1`, `ramWEN=0`, `ramstore=0`.
- Completion
  - In the granted state, `ramstate==ACCESS` drops that requester's wait combinationally in the same cycle. The FSM returns to IDLE on the next edge.
- Error
  - `ramstate==ERROR` in a granted state: the wait stays high, enables drop combinationally, and the FSM returns to IDLE.
  - The requester is still requesting, so it is re-arbitrated (retry).
- Abort
  - If the granted requester deasserts its request mid-grant, enables drop in that cycle and the FSM returns to IDLE.
  - No completion is signalled.
- Read data
  - `iload=ramload` and `dload=ramload` continuously, combinational.
  - Data is valid only in the cycle where the matching wait is 0.
- Wait signals
  - `iwait=~(state==IGNT && ramstate==ACCESS)`.
  - `dwait=~(state==DGNT && ramstate==ACCESS)`.
- Requester rule: a requester holds its request and address stable until its wait is 0.

## Timing
- Reset values:
  - State is IDLE and the starvation counter is 0.
  - `ramREN=0`, `ramWEN=0`, `ramaddr=0`, `ramstore=0`.
  - `iwait=1`, `dwait=1`.
  - `iload`/`dload` follow `ramload`.
- Minimum latency: request seen in IDLE at cycle 0, grant at cycle 1. If `ACCESS` arrives in cycle 1, wait is low in cycle 1, so there are 2 cycles from request to completion.
- Each extra `BUSY`/`FREE` cycle from the RAM adds one cycle.
- There is one idle arbitration cycle between any two transactions. Back-to-back is IDLE→grant→IDLE→grant.
- Simultaneous `iREN` and `dREN` in IDLE: data wins, unless a fairness override is active.
- `RST` asserted mid-transaction forces IDLE and deasserts enables immediately, asynchronously. The in-flight access is abandoned.

## Configuration
- `MEM_ARB_FAIR_EN` defined:
  - A 4-bit counter increments on each DGNT entry taken while `iREN` is high.
  - It clears on IGNT entry, or when IDLE is entered with `iREN` low.
  - When counter==`STARVE_LIMIT` and `iREN` is high in IDLE, IGNT is chosen even if data is requesting.
  - The counter saturates and does not wrap.
- `MEM_ARB_FAIR_EN` undefined: strict data priority. No counter is present, and `STARVE_LIMIT` is ignored.

## Test plan
- Reset and idle: assert `RST` mid-IGNT with `ramstate=BUSY`. Required response: `ramREN=0` immediately, `iwait=1`, `dwait=1`, state IDLE after release.
- Single fetch: `iREN=1`, `iaddr=0x40`, RAM returns `ACCESS` in the first grant cycle with `ramload=0x8C220004`. Required response: `ramREN=1`, `ramaddr=0x40`, `iwait=0` in cycle 1, `iload=0x8C220004`.
- Contention: `iREN` and `dWEN` raised together, `daddr=0x100`, `dstore=0xDEADBEEF`, 2 `BUSY` cycles then `ACCESS`.
  - Data completes first, at cycle 3.
  - The fetch is granted at cycle 5.
- Error retry: `dREN` with the RAM returning `ERROR` once, then `ACCESS` on the retry.
  - `dwait` stays 1 through the error.
  - The FSM passes through IDLE and re-grants.
  - `dwait=0` on the retry's `ACCESS`.
- Abort: drop `dREN` during DGNT `BUSY`. Required response: `ramREN=0` in the same cycle, IDLE next cycle, `dwait` never low.
- Fairness, with `MEM_ARB_FAIR_EN` and `STARVE_LIMIT=2`: `iREN` held high while data requests continuously.
  - Grant order is D, D, I, D, D, I.
  - Without the macro, I is never granted while data keeps requesting.
